// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command parser.
package uart_cmd_pkg;
   typedef enum logic [1:0] {IDLE, GOT_HEAD, GOT_CMD, GOT_CHK} state_t;

   localparam logic [7:0] DEF_HEAD = 8'hAA;
   localparam logic [7:0] DEF_TAIL = 8'h55;

   localparam logic [1:0] CMD_OFF  = 2'b00;
   localparam logic [1:0] CMD_LED  = 2'b01;
   localparam logic [1:0] CMD_BEEP = 2'b10;
   localparam logic [1:0] CMD_BOTH = 2'b11;
endpackage

// File: rtl/byte_timeout.sv
// Inter-byte gap counter; expire is suppressed whenever clr is asserted so a
// byte arriving in the expiry cycle always wins.
module byte_timeout #(
   parameter int LIMIT = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);
   localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

   logic [W-1:0] cnt;

   assign expire = en && !clr && (cnt == W'(LIMIT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             cnt <= '0;
      else if (clr || expire) cnt <= '0;
      else if (en)            cnt <= cnt + W'(1);
   end
endmodule

// File: rtl/uart_cmd_parser.sv
// Framed command parser: HEAD, C, ~C, TAIL -> registered 2-bit cmd with
// one-cycle cmd_vld / frm_err strobes and an inter-byte timeout.
module uart_cmd_parser
   import uart_cmd_pkg::*;
#(
   parameter int          CLK_FREQ   = 50_000_000,
   parameter int          TIMEOUT_MS = 10,
   parameter logic [7:0]  HEAD       = DEF_HEAD,
   parameter logic [7:0]  TAIL       = DEF_TAIL
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_vld,
   output logic [1:0] cmd,
   output logic       cmd_vld,
   output logic       frm_err,
   output logic       busy
);
   localparam int LIMIT = CLK_FREQ / 1000 * TIMEOUT_MS;

   state_t     state, state_nxt;
   logic [7:0] cmd_buf, buf_nxt;
   logic [1:0] cmd_nxt;
   logic       vld_nxt, err_nxt, bad, expire;

   byte_timeout #(.LIMIT(LIMIT)) u_tmo (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (rx_vld || state == IDLE),
      .en     (state != IDLE),
      .expire (expire)
   );

   always_comb begin
      state_nxt = state;
      buf_nxt   = cmd_buf;
      cmd_nxt   = cmd;
      vld_nxt   = 1'b0;
      err_nxt   = 1'b0;
      bad       = 1'b0;
      case (state)
         IDLE:     if (rx_vld && rx_data == HEAD) state_nxt = GOT_HEAD;
         GOT_HEAD: if (rx_vld) begin
            buf_nxt = rx_data;
            if (rx_data[7:2] != 6'd0) bad = 1'b1;
            else                      state_nxt = GOT_CMD;
         end
         GOT_CMD:  if (rx_vld) begin
            if (rx_data == ~cmd_buf) state_nxt = GOT_CHK;
            else                     bad = 1'b1;
         end
         GOT_CHK:  if (rx_vld) begin
            if (rx_data == TAIL) begin
               cmd_nxt   = cmd_buf[1:0];
               vld_nxt   = 1'b1;
               state_nxt = IDLE;
            end else begin
               bad = 1'b1;
            end
         end
         default:  state_nxt = IDLE;
      endcase
      // A rejected byte that is itself a header starts the next frame.
      if (bad) begin
         err_nxt   = 1'b1;
         state_nxt = (rx_data == HEAD) ? GOT_HEAD : IDLE;
      end
      if (expire) begin
         err_nxt   = 1'b1;
         state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cmd_buf <= '0;
         cmd     <= CMD_OFF;
         cmd_vld <= 1'b0;
         frm_err <= 1'b0;
      end else begin
         state   <= state_nxt;
         cmd_buf <= buf_nxt;
         cmd     <= cmd_nxt;
         cmd_vld <= vld_nxt;
         frm_err <= err_nxt;
      end
   end

   assign busy = (state != IDLE);
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomized bench for uart_cmd_parser against a byte-queue reference model.
module tb_uart_cmd_parser;
   localparam int         CLK_FREQ   = 64_000;
   localparam int         TIMEOUT_MS = 1;
   localparam int         LIMIT      = CLK_FREQ / 1000 * TIMEOUT_MS;
   localparam logic [7:0] HEAD       = 8'hAA;
   localparam logic [7:0] TAIL       = 8'h55;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_data = '0;
   logic       rx_vld = 1'b0;
   logic [1:0] cmd;
   logic       cmd_vld, frm_err, busy;

   uart_cmd_parser #(
      .CLK_FREQ(CLK_FREQ), .TIMEOUT_MS(TIMEOUT_MS), .HEAD(HEAD), .TAIL(TAIL)
   ) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_vld(rx_vld),
      .cmd(cmd), .cmd_vld(cmd_vld), .frm_err(frm_err), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   // Reference model: bytes of the frame collected so far, plus the edge
   // index of the last byte seen, used for the gap timeout.
   logic [7:0] fq[$];
   int         cyc = 0;
   int         last = 0;
   logic [1:0] m_cmd = 2'b00;
   logic       m_vld = 1'b0;
   logic       m_err = 1'b0;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_edge(input logic v, input logic [7:0] d);
      logic rej;
      cyc++;
      m_vld = 1'b0;
      m_err = 1'b0;
      rej   = 1'b0;
      if (v) begin
         last = cyc;
         case (fq.size())
            0: if (d == HEAD) fq.push_back(d);
            1: if (d > 8'd3) rej = 1'b1; else fq.push_back(d);
            2: if (d == 8'(~fq[1])) fq.push_back(d); else rej = 1'b1;
            default: if (d == TAIL) begin
               m_cmd = fq[1][1:0];
               m_vld = 1'b1;
               fq.delete();
            end else rej = 1'b1;
         endcase
         if (rej) begin
            m_err = 1'b1;
            fq.delete();
            if (d == HEAD) fq.push_back(d);
         end
      end else if (fq.size() > 0 && cyc - last == LIMIT) begin
         m_err = 1'b1;
         fq.delete();
      end
   endfunction

   task automatic step(input logic v, input logic [7:0] d);
      rx_vld  = v;
      rx_data = d;
      model_edge(v, d);
      @(posedge clk);
      #1;
      rx_vld = 1'b0;
      chk("cmd", {6'd0, cmd}, {6'd0, m_cmd});
      chk("cmd_vld", {7'd0, cmd_vld}, {7'd0, m_vld});
      chk("frm_err", {7'd0, frm_err}, {7'd0, m_err});
      chk("busy", {7'd0, busy}, {7'd0, 1'b0} | (fq.size() > 0));
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      for (int i = 0; i < gap; i++) step(1'b0, 8'h00);
      step(1'b1, b);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_cmd", {6'd0, cmd}, 8'h00);
      chk("rst_vld", {7'd0, cmd_vld}, 8'h00);
      chk("rst_err", {7'd0, frm_err}, 8'h00);
      chk("rst_busy", {7'd0, busy}, 8'h00);
      fq.delete();
      m_cmd = 2'b00;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic int rgap();
      int r;
      r = $urandom_range(0, 11);
      if (r == 0) return LIMIT - 1;
      if (r == 1) return LIMIT;
      if (r == 2) return LIMIT - 2 + 4 * $urandom_range(0, 1);
      return $urandom_range(0, 3);
   endfunction

   initial begin
      logic [7:0] fr[$];
      logic [7:0] c;
      #1;
      chk("init_cmd", {6'd0, cmd}, 8'h00);
      chk("init_busy", {7'd0, busy}, 8'h00);
      do_reset();

      // Valid frame, 20 cycles between bytes
      send(8'hAA, 19); send(8'h01, 19); send(8'hFE, 19); send(8'h55, 19);
      chk("tp_led_cmd", {6'd0, cmd}, 8'h01);
      chk("tp_led_vld", {7'd0, cmd_vld}, 8'h01);
      // Bad check byte, then stray TAIL ignored
      send(8'hAA, 2); send(8'h02, 0); send(8'hFC, 0);
      chk("tp_badchk_err", {7'd0, frm_err}, 8'h01);
      send(8'h55, 0);
      chk("tp_badchk_cmd", {6'd0, cmd}, 8'h01);
      // Out-of-range command, then full frame
      send(8'hAA, 1); send(8'h07, 1);
      chk("tp_range_err", {7'd0, frm_err}, 8'h01);
      send(8'hAA, 0); send(8'h03, 0); send(8'hFC, 0); send(8'h55, 0);
      chk("tp_both_cmd", {6'd0, cmd}, 8'h03);
      // Resync on a second header
      send(8'hAA, 3); send(8'h01, 0); send(8'hAA, 0);
      chk("tp_resync_err", {7'd0, frm_err}, 8'h01);
      send(8'h02, 0); send(8'hFD, 0); send(8'h55, 0);
      chk("tp_resync_cmd", {6'd0, cmd}, 8'h02);
      // Timeout after AA 01
      send(8'hAA, 2); send(8'h01, 0);
      for (int i = 0; i < LIMIT - 1; i++) step(1'b0, 8'h00);
      chk("tp_tmo_early", {7'd0, frm_err}, 8'h00);
      step(1'b0, 8'h00);
      chk("tp_tmo_err", {7'd0, frm_err}, 8'h01);
      chk("tp_tmo_busy", {7'd0, busy}, 8'h00);
      send(8'hAA, 0); send(8'h00, 0); send(8'hFF, 0); send(8'h55, 0);
      chk("tp_off_cmd", {6'd0, cmd}, 8'h00);
      chk("tp_off_vld", {7'd0, cmd_vld}, 8'h01);
      // Byte lands in the expiry cycle: no error, frame completes
      send(8'hAA, 1); send(8'h01, LIMIT - 1);
      chk("tp_coll_err", {7'd0, frm_err}, 8'h00);
      send(8'hFE, LIMIT - 1); send(8'h55, LIMIT - 1);
      chk("tp_coll_cmd", {6'd0, cmd}, 8'h01);
      // Reset mid-frame
      send(8'hAA, 1); send(8'h02, 0);
      do_reset();
      send(8'h55, 0);
      chk("tp_rst_stray", {7'd0, cmd_vld | frm_err}, 8'h00);
      send(8'hAA, 0); send(8'h02, 0); send(8'hFD, 0); send(8'h55, 0);
      chk("tp_rst_cmd", {6'd0, cmd}, 8'h02);

      // Randomized frames with corruption, junk, truncation and long gaps
      repeat (300) begin
         int r;
         c = 8'($urandom_range(0, 3));
         fr = '{HEAD, c, ~c, TAIL};
         r = $urandom_range(0, 9);
         if (r == 0) fr[$urandom_range(0, 3)] = 8'($urandom_range(0, 255));
         if (r == 1) fr.push_front(8'($urandom_range(0, 255)));
         if (r == 2) fr = fr[0:$urandom_range(0, 2)];
         if (r == 3) fr[$urandom_range(1, 3)] = HEAD;
         foreach (fr[i]) send(fr[i], rgap());
         if ($urandom_range(0, 39) == 0) do_reset();
      end
      for (int i = 0; i < LIMIT + 2; i++) step(1'b0, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
